// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: state type,
// opcode constants, mux-select encodings and the control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Everything the decoder drives for one state.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

  // beq takes the branch on zero, bne on not-zero; other funct3 never branch.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and flags in, selects/enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  // Controller side
  modport master (
    input  op, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_op, reg_write, instr_done, illegal
  );

  // Datapath side
  modport slave (
    output op, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_op, reg_write, instr_done, illegal
  );
endinterface

// File: rtl/mc_out_decode.sv
// Pure combinational state -> control mapping for the multi-cycle core.
// mem_ok gates the memory-side enables so a stalled state drives no writes.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ok,
  output ctrl_t      ctrl
);

  // Per-state select and enable values; anything unlisted stays zero.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = mem_ok;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_write   = mem_ok;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_src   = IMM_B;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = mem_ok;
        ctrl.instr_done = mem_ok;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_REGA;
        ctrl.alu_src_b  = SRCB_REGB;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = branch_taken(funct3, zero);
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core. Holds the state register,
// next-state logic and the sticky illegal flag; output mapping lives in
// mc_out_decode. Optional feature macro: MCCTRL_MEM_WAIT_EN (FETCH, MEMREAD
// and MEMWRITE stall until mem_ready).
module multicycle_controller
  import mc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  state_t state;
  state_t state_nxt;
  state_t state_view;
  logic   illegal_q;
  logic   mem_ok;
  ctrl_t  ctrl_raw;

`ifdef MCCTRL_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // State register and sticky illegal flag (set on entry to TRAP).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Next-state: sequence the datapath; memory states hold while stalled.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    state_nxt = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = mem_ok ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = mem_ok ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   state_nxt = S_ALUWB;
      S_EXEC_I:   state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // While in reset the muxes present FETCH values regardless of state.
  assign state_view = rst ? S_FETCH : state;

  mc_out_decode u_out_decode (
    .state  (state_view),
    .op     (bus.op),
    .funct3 (bus.funct3),
    .zero   (bus.zero),
    .mem_ok (mem_ok),
    .ctrl   (ctrl_raw)
  );

  // Drive the bus; every write enable is suppressed in a reset cycle so an
  // in-flight instruction is aborted without side effects.
  always_comb begin
    bus.pc_write   = ctrl_raw.pc_write   & ~rst;
    bus.ir_write   = ctrl_raw.ir_write   & ~rst;
    bus.mem_write  = ctrl_raw.mem_write  & ~rst;
    bus.reg_write  = ctrl_raw.reg_write  & ~rst;
    bus.instr_done = ctrl_raw.instr_done & ~rst;
    bus.adr_src    = ctrl_raw.adr_src;
    bus.result_src = ctrl_raw.result_src;
    bus.alu_src_a  = ctrl_raw.alu_src_a;
    bus.alu_src_b  = ctrl_raw.alu_src_b;
    bus.imm_src    = ctrl_raw.imm_src;
    bus.alu_op     = ctrl_raw.alu_op;
    bus.illegal    = illegal_q;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle RV32I core. It sequences the shared datapath (one memory port, one ALU, PC/IR/ALUOut/Data registers) through fetch, decode, execute, memory and writeback, one instruction at a time. It drives every mux select and write enable from the current state, the opcode and the ALU `zero` flag. The ALU decoder stays a separate combinational block fed by `alu_op`.

## Interface
- No parameters. Encodings come from `mc_pkg`.
- `clk` input 1 — core clock, rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `op` input 7 — IR[6:0].
- `funct3` input 3 — IR[14:12], used for branch polarity.
- `zero` input 1 — ALU zero flag from the current cycle.
- `mem_ready` input 1 — memory handshake; used only with `MCCTRL_MEM_WAIT_EN`.
- `pc_write` output 1 — PC load enable.
- `adr_src` output 1 — memory address select: 0=PC, 1=Result.
- `mem_write` output 1 — memory store enable.
- `ir_write` output 1 — IR and OldPC load enable.
- `result_src` output 2 — 00=ALUOut, 01=Data, 10=ALUResult.
- `alu_src_a` output 2 — 00=PC, 01=OldPC, 10=RegA.
- `alu_src_b` output 2 — 00=RegB, 01=Imm, 10=const 4.
- `imm_src` output 2 — 00=I, 01=S, 10=B, 11=J.
- `alu_op` output 2 — 00=add, 01=sub/compare, 10=funct-decoded.
- `reg_write` output 1 — register file write enable.
- `instr_done` output 1 — one-cycle pulse in the last cycle of each instruction.
- `illegal` output 1 — sticky unsupported-opcode flag.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP.

Outputs per state. Anything not listed is 0 or 00.
- **FETCH:** adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1.
- **DECODE:** alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=10 (precomputes the branch target into ALUOut).
- **MEMADR:** alu_src_a=10, alu_src_b=01, alu_op=00, imm_src=00 for load and 01 for store.
- **MEMREAD:** result_src=00, adr_src=1.
- **MEMWB:** result_src=01, reg_write=1.
- **MEMWRITE:** result_src=00, adr_src=1, mem_write=1.
- **EXEC_R:** alu_src_a=10, alu_src_b=00, alu_op=10.
- **EXEC_I:** alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10.
- **ALUWB:** result_src=00, reg_write=1.
- **BRANCH:** alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=(funct3==000 ? zero : funct3==001 ? ~zero : 0).
- **JAL:** alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; then go to ALUWB.

Transitions:
- FETCH→DECODE.
- DECODE by `op`:
  - 0000011 and 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other → TRAP
- MEMADR→MEMREAD for a load, MEMWRITE for a store. `op` is held stable by the IR.
- MEMREAD→MEMWB; EXEC_R and EXEC_I→ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH→FETCH, with `instr_done`=1 in that cycle.
- TRAP is absorbing: all enables 0, `illegal`=1. Only `rst` exits it.

Reset:
- `rst` high at an edge → state=FETCH, `illegal`=0.
- While `rst` is high, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `instr_done` are forced to 0. Muxes show FETCH values.
- Reset in any state, including mid-store, aborts the instruction. No write enable is asserted in the reset cycle.

## Timing
- All outputs are combinational from the state register, plus `zero`/`funct3` in BRANCH. No output registers.
- Cycles per instruction without waits: load 5, store 4, R 4, I 4, branch 3, jal 4.
- The first FETCH outputs appear in the cycle after `rst` deasserts.

## Configuration
- **`MCCTRL_MEM_WAIT_EN` defined:**
  - FETCH, MEMREAD and MEMWRITE hold until `mem_ready`=1.
  - While waiting, `pc_write`, `ir_write` and `mem_write` are 0. The mux selects stay at their state values.
  - The enables assert only in the cycle where `mem_ready`=1, and the state advances on that edge.
- **Not defined:** `mem_ready` is ignored and every state is a single cycle.

## Structure
- `mc_pkg` holds:
  - the state enum type;
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL);
  - IMM_*, ALUOP_*, SRCA_*, SRCB_*, RES_* encodings.
- Sub-module `mc_out_decode`: pure combinational state→control mapping. The top keeps the state register, next-state logic and sticky `illegal`.

## Test plan
- **Reset:** hold `rst` 2 cycles with the FSM in MEMWRITE → `mem_write`=0 throughout. The next cycle is FETCH with `ir_write`=1 and `pc_write`=1.
- **Load:** op=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write`=1 and `result_src`=01 only in cycle 5, with `instr_done` pulsing there.
- **Branch:**
  - op=1100011, funct3=000, zero=1 in BRANCH → `pc_write`=1, 3-cycle instruction.
  - Same with zero=0 → `pc_write`=0.
  - funct3=001 with zero=0 → `pc_write`=1.
- **Illegal opcode:** op=0001111 → TRAP after DECODE. `illegal` stays 1 for 20 cycles with all enables 0, then clears on `rst`.
- **Memory wait** (with `MCCTRL_MEM_WAIT_EN`): store with `mem_ready` low for 3 cycles in MEMWRITE → `mem_write`=0 for those cycles, then 1 for exactly one cycle, then FETCH.
- **Back-to-back:** R-type then jal → 4+4 cycles. JAL has `pc_write`=1 and `alu_src_a`=01; the following ALUWB has `reg_write`=1.
